// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match-level controller for Pong.
// Decodes UART command bytes, tracks both scores, counts serve delays in
// frame ticks (rising edges of VSync) and detects the end of the match.
// Ports:
//   i_Clk, i_Rst            clock, synchronous active-high reset
//   i_Rx_DV, i_Rx_Byte      received UART byte and its valid strobe
//   i_VSync                 vertical sync, its rising edge is the frame tick
//   i_Miss_P1, i_Miss_P2    ball passed the left / right edge
//   o_Game_Active           ball and paddles move (PLAY only)
//   o_Ball_Reset            playfield holds ball at centre
//   o_Serve_Dir             0 = serve toward P2, 1 = toward P1
//   o_CPU_P2                P2 paddle under CPU control
//   o_Score_P1, o_Score_P2  scores
//   o_Winner                0 none, 1 P1, 2 P2
//   o_State                 IDLE=0 SERVE=1 PLAY=2 PAUSE=3 OVER=4
module pong_match_ctrl #(
  parameter int SCORE_WIDTH        = 4,
  parameter int WIN_SCORE          = 9,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int STRICT_CMD         = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Rx_DV,
  input  logic [7:0]             i_Rx_Byte,
  input  logic                   i_VSync,
  input  logic                   i_Miss_P1,
  input  logic                   i_Miss_P2,
  output logic                   o_Game_Active,
  output logic                   o_Ball_Reset,
  output logic                   o_Serve_Dir,
  output logic                   o_CPU_P2,
  output logic [SCORE_WIDTH-1:0] o_Score_P1,
  output logic [SCORE_WIDTH-1:0] o_Score_P2,
  output logic [1:0]             o_Winner,
  output logic [2:0]             o_State
);

  localparam int CNT_W = (SERVE_DELAY_FRAMES < 1) ? 1 : $clog2(SERVE_DELAY_FRAMES + 1);
  localparam logic [CNT_W-1:0]       CNT_LOAD = CNT_W'(SERVE_DELAY_FRAMES);
  localparam logic [SCORE_WIDTH-1:0] WIN      = SCORE_WIDTH'(WIN_SCORE);

  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] CMD_CPU   = 8'h43;
  localparam logic [7:0] CMD_RESET = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SCORE_WIDTH-1:0] score_p1_q, score_p1_d;
  logic [SCORE_WIDTH-1:0] score_p2_q, score_p2_d;
  logic [1:0]             winner_q, winner_d;
  logic                   serve_dir_q, serve_dir_d;
  logic                   cpu_p2_q, cpu_p2_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   vsync_q, vsync_d;
  logic                   game_active_q, game_active_d;
  logic                   ball_reset_q, ball_reset_d;

  logic                   tick;
  logic                   cmd_start, cmd_pause, cmd_cpu, cmd_reset;
  logic                   known_cmd;
  logic [SCORE_WIDTH-1:0] p1_inc, p2_inc;

  always_comb begin
    vsync_d = i_VSync;
    tick    = i_VSync & ~vsync_q;

    known_cmd = (i_Rx_Byte == CMD_PAUSE) || (i_Rx_Byte == CMD_CPU) ||
                (i_Rx_Byte == CMD_RESET);
    cmd_pause = i_Rx_DV && (i_Rx_Byte == CMD_PAUSE);
    cmd_cpu   = i_Rx_DV && (i_Rx_Byte == CMD_CPU);
    cmd_reset = i_Rx_DV && (i_Rx_Byte == CMD_RESET);
    // Legacy mode: any byte that is not P/C/R starts the game.
    cmd_start = i_Rx_DV && ((i_Rx_Byte == CMD_START) ||
                            ((STRICT_CMD == 0) && !known_cmd));

    p1_inc = score_p1_q + 1'b1;
    p2_inc = score_p2_q + 1'b1;

    state_d     = state_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;
    winner_d    = winner_q;
    serve_dir_d = serve_dir_q;
    cpu_p2_d    = cpu_p2_q;
    cnt_d       = cnt_q;

    if (cmd_reset) begin
      state_d    = ST_IDLE;
      score_p1_d = '0;
      score_p2_d = '0;
      winner_d   = '0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (cmd_start) begin
            state_d     = ST_SERVE;
            score_p1_d  = '0;
            score_p2_d  = '0;
            winner_d    = '0;
            serve_dir_d = 1'b0;
            cnt_d       = CNT_LOAD;
          end
          if (cmd_cpu) cpu_p2_d = ~cpu_p2_q;
        end
        ST_SERVE: begin
          if (tick) begin
            if (cnt_q == '0) state_d = ST_PLAY;
            else             cnt_d   = cnt_q - 1'b1;
          end
        end
        ST_PLAY: begin
          // A miss outranks a Pause arriving in the same cycle.
          if (i_Miss_P1 && i_Miss_P2) begin
            state_d = ST_SERVE;
            cnt_d   = CNT_LOAD;
          end else if (i_Miss_P1) begin
            score_p2_d  = p2_inc;
            serve_dir_d = 1'b1;
            if (p2_inc == WIN) begin
              state_d  = ST_OVER;
              winner_d = 2'd2;
            end else begin
              state_d = ST_SERVE;
              cnt_d   = CNT_LOAD;
            end
          end else if (i_Miss_P2) begin
            score_p1_d  = p1_inc;
            serve_dir_d = 1'b0;
            if (p1_inc == WIN) begin
              state_d  = ST_OVER;
              winner_d = 2'd1;
            end else begin
              state_d = ST_SERVE;
              cnt_d   = CNT_LOAD;
            end
          end else if (cmd_pause) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (cmd_pause) state_d = ST_PLAY;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs decoded from the next state so they register alongside it.
    game_active_d = (state_d == ST_PLAY);
    ball_reset_d  = !((state_d == ST_PLAY) || (state_d == ST_PAUSE));
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q       <= ST_IDLE;
      score_p1_q    <= '0;
      score_p2_q    <= '0;
      winner_q      <= '0;
      serve_dir_q   <= 1'b0;
      cpu_p2_q      <= 1'b0;
      cnt_q         <= '0;
      vsync_q       <= 1'b0;
      game_active_q <= 1'b0;
      ball_reset_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      score_p1_q    <= score_p1_d;
      score_p2_q    <= score_p2_d;
      winner_q      <= winner_d;
      serve_dir_q   <= serve_dir_d;
      cpu_p2_q      <= cpu_p2_d;
      cnt_q         <= cnt_d;
      vsync_q       <= vsync_d;
      game_active_q <= game_active_d;
      ball_reset_q  <= ball_reset_d;
    end
  end

  assign o_Game_Active = game_active_q;
  assign o_Ball_Reset  = ball_reset_q;
  assign o_Serve_Dir   = serve_dir_q;
  assign o_CPU_P2      = cpu_p2_q;
  assign o_Score_P1    = score_p1_q;
  assign o_Score_P2    = score_p2_q;
  assign o_Winner      = winner_q;
  assign o_State       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed bench for pong_match_ctrl.
// Instance a: WIN_SCORE=3, SERVE_DELAY_FRAMES=3, strict commands.
// Instance b: legacy command decode with zero serve delay.
// Packed output view: {state[2:0], winner[1:0], p1[3:0], p2[3:0],
//                      game_active, ball_reset, serve_dir, cpu_p2}.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       rst, rx_dv, vsync, miss1, miss2;
  logic [7:0] rx_byte;

  logic       a_ga, a_br, a_sd, a_cpu, b_ga, b_br, b_sd, b_cpu;
  logic [3:0] a_s1, a_s2, b_s1, b_s2;
  logic [1:0] a_win, b_win;
  logic [2:0] a_st, b_st;
  logic [16:0] a_all, b_all;

  int errs   = 0;
  int checks = 0;

  assign a_all = {a_st, a_win, a_s1, a_s2, a_ga, a_br, a_sd, a_cpu};
  assign b_all = {b_st, b_win, b_s1, b_s2, b_ga, b_br, b_sd, b_cpu};

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .SCORE_WIDTH(4), .WIN_SCORE(3), .SERVE_DELAY_FRAMES(3), .STRICT_CMD(1)
  ) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .i_VSync(vsync), .i_Miss_P1(miss1), .i_Miss_P2(miss2),
    .o_Game_Active(a_ga), .o_Ball_Reset(a_br), .o_Serve_Dir(a_sd),
    .o_CPU_P2(a_cpu), .o_Score_P1(a_s1), .o_Score_P2(a_s2),
    .o_Winner(a_win), .o_State(a_st)
  );

  pong_match_ctrl #(
    .SCORE_WIDTH(4), .WIN_SCORE(9), .SERVE_DELAY_FRAMES(0), .STRICT_CMD(0)
  ) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .i_VSync(vsync), .i_Miss_P1(miss1), .i_Miss_P2(miss2),
    .o_Game_Active(b_ga), .o_Ball_Reset(b_br), .o_Serve_Dir(b_sd),
    .o_CPU_P2(b_cpu), .o_Score_P1(b_s1), .o_Score_P2(b_s2),
    .o_Winner(b_win), .o_State(b_st)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b;
    step();
    rx_dv = 1'b0; rx_byte = 8'h00;
  endtask

  task automatic vtick();
    vsync = 1'b1; step();
    vsync = 1'b0; step();
  endtask

  task automatic to_play();
    repeat (4) vtick();
  endtask

  task automatic miss(input logic m1, input logic m2, input logic with_pause);
    miss1 = m1; miss2 = m2;
    if (with_pause) begin rx_dv = 1'b1; rx_byte = 8'h50; end
    step();
    miss1 = 1'b0; miss2 = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    if (a_all !== 17'b000_00_0000_0000_0100) begin
      $display("FAIL reset_a: got %h want %h", a_all, 17'b000_00_0000_0000_0100); errs++;
    end
    checks++;
    if (b_all !== 17'b000_00_0000_0000_0100) begin
      $display("FAIL reset_b: got %h want %h", b_all, 17'b000_00_0000_0000_0100); errs++;
    end
    checks++;
  endtask

  task automatic test_serve();
    send(8'h53);
    if (a_all !== 17'b001_00_0000_0000_0100) begin
      $display("FAIL start: got %h want %h", a_all, 17'b001_00_0000_0000_0100); errs++;
    end
    checks++;
    // VSync held high for several cycles yields one tick only.
    vsync = 1'b1; repeat (3) step(); vsync = 1'b0; step();
    vtick(); vtick();
    if (a_st !== 3'd1) begin
      $display("FAIL serve_3_ticks: got %0d want 1", a_st); errs++;
    end
    checks++;
    vtick();
    if (a_all !== 17'b010_00_0000_0000_1000) begin
      $display("FAIL serve_to_play: got %h want %h", a_all, 17'b010_00_0000_0000_1000); errs++;
    end
    checks++;
  endtask

  task automatic test_score();
    miss(1'b0, 1'b1, 1'b0);
    if (a_all !== 17'b001_00_0001_0000_0100) begin
      $display("FAIL miss_p2: got %h want %h", a_all, 17'b001_00_0001_0000_0100); errs++;
    end
    checks++;
    to_play();
    miss(1'b1, 1'b0, 1'b0);
    if (a_all !== 17'b001_00_0001_0001_0110) begin
      $display("FAIL miss_p1: got %h want %h", a_all, 17'b001_00_0001_0001_0110); errs++;
    end
    checks++;
  endtask

  task automatic test_win();
    to_play(); miss(1'b0, 1'b1, 1'b0);
    to_play(); miss(1'b0, 1'b1, 1'b0);
    if (a_all !== 17'b100_01_0011_0001_0100) begin
      $display("FAIL win_p1: got %h want %h", a_all, 17'b100_01_0011_0001_0100); errs++;
    end
    checks++;
    miss(1'b0, 1'b1, 1'b0);
    miss(1'b1, 1'b0, 1'b0);
    if (a_all !== 17'b100_01_0011_0001_0100) begin
      $display("FAIL over_hold: got %h want %h", a_all, 17'b100_01_0011_0001_0100); errs++;
    end
    checks++;
    send(8'h53);
    if (a_all !== 17'b001_00_0000_0000_0100) begin
      $display("FAIL restart: got %h want %h", a_all, 17'b001_00_0000_0000_0100); errs++;
    end
    checks++;
  endtask

  task automatic test_both_misses();
    to_play(); miss(1'b1, 1'b0, 1'b0);
    to_play(); miss(1'b1, 1'b1, 1'b0);
    if (a_all !== 17'b001_00_0000_0001_0110) begin
      $display("FAIL let: got %h want %h", a_all, 17'b001_00_0000_0001_0110); errs++;
    end
    checks++;
    to_play(); miss(1'b1, 1'b0, 1'b1);
    if (a_all !== 17'b001_00_0000_0010_0110) begin
      $display("FAIL miss_beats_pause: got %h want %h", a_all, 17'b001_00_0000_0010_0110); errs++;
    end
    checks++;
  endtask

  task automatic test_pause_cpu();
    to_play();
    send(8'h50);
    if (a_all !== 17'b011_00_0000_0010_0010) begin
      $display("FAIL pause: got %h want %h", a_all, 17'b011_00_0000_0010_0010); errs++;
    end
    checks++;
    miss(1'b0, 1'b1, 1'b0); vtick(); send(8'h53);
    if (a_all !== 17'b011_00_0000_0010_0010) begin
      $display("FAIL pause_ignores: got %h want %h", a_all, 17'b011_00_0000_0010_0010); errs++;
    end
    checks++;
    send(8'h50); send(8'h43); send(8'h53);
    if (a_all !== 17'b010_00_0000_0010_1010) begin
      $display("FAIL resume_cpu_ignored: got %h want %h", a_all, 17'b010_00_0000_0010_1010); errs++;
    end
    checks++;
    send(8'h52);
    if (a_all !== 17'b000_00_0000_0000_0110) begin
      $display("FAIL reset_cmd: got %h want %h", a_all, 17'b000_00_0000_0000_0110); errs++;
    end
    checks++;
    send(8'h43);
    if (a_cpu !== 1'b1) begin
      $display("FAIL cpu_idle: got %b want 1", a_cpu); errs++;
    end
    checks++;
    send(8'h53); send(8'h43); send(8'h52);
    if (a_all !== 17'b000_00_0000_0000_0101) begin
      $display("FAIL cpu_kept: got %h want %h", a_all, 17'b000_00_0000_0000_0101); errs++;
    end
    checks++;
  endtask

  task automatic test_legacy();
    pulse_reset();
    send(8'h41);
    if (a_st !== 3'd0) begin
      $display("FAIL strict_ignore: got %0d want 0", a_st); errs++;
    end
    checks++;
    if (b_all !== 17'b001_00_0000_0000_0100) begin
      $display("FAIL legacy_start: got %h want %h", b_all, 17'b001_00_0000_0000_0100); errs++;
    end
    checks++;
    send(8'h50);
    if (a_st !== 3'd0) begin
      $display("FAIL pause_in_idle: got %0d want 0", a_st); errs++;
    end
    checks++;
    vtick();
    if (b_all !== 17'b010_00_0000_0000_1000) begin
      $display("FAIL zero_delay: got %h want %h", b_all, 17'b010_00_0000_0000_1000); errs++;
    end
    checks++;
  endtask

  task automatic test_rst_mid();
    send(8'h43); send(8'h53);
    rst = 1'b1; rx_dv = 1'b1; rx_byte = 8'h43; vsync = 1'b1; miss1 = 1'b1;
    step();
    rst = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; vsync = 1'b0; miss1 = 1'b0;
    if (a_all !== 17'b000_00_0000_0000_0100) begin
      $display("FAIL rst_mid: got %h want %h", a_all, 17'b000_00_0000_0000_0100); errs++;
    end
    checks++;
  endtask

  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; vsync = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
    test_reset();
    test_serve();
    test_score();
    test_win();
    test_both_misses();
    test_pause_cpu();
    test_legacy();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
